// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for a single-port data memory.
// Optional DMEM_ARB_RR_EN selects round-robin arbitration instead of fixed priority with starvation forcing.
module dmem_arbiter #(
    parameter int AW           = 12,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_write_data,
    output logic          mem_write,
    output logic          mem_read,
    input  logic [DW-1:0] mem_read_data
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t state;
    logic   sel;
    logic   pick1;

`ifdef DMEM_ARB_RR_EN
    // ptr names the port preferred on the next tie (the one that lost last time)
    logic ptr;

    always_comb begin
        pick1 = 1'b0;
        if (req1 && (!req0 || ptr))
            pick1 = 1'b1;
    end
`else
    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;
    logic          starved;

    assign starved = (STARVE_LIMIT > 0) && (starve_cnt == CW'(STARVE_LIMIT));

    always_comb begin
        pick1 = 1'b0;
        if (req1 && (!req0 || starved))
            pick1 = 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            sel            <= 1'b0;
            gnt0           <= 1'b0;
            gnt1           <= 1'b0;
            rvalid0        <= 1'b0;
            rvalid1        <= 1'b0;
            rdata0         <= '0;
            rdata1         <= '0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            ptr            <= 1'b0;
`else
            starve_cnt     <= '0;
`endif
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        sel            <= pick1;
                        gnt0           <= !pick1;
                        gnt1           <= pick1;
                        mem_addr       <= pick1 ? addr1 : addr0;
                        mem_write_data <= pick1 ? wdata1 : wdata0;
                        mem_write      <= pick1 ? we1 : we0;
                        mem_read       <= pick1 ? !we1 : !we0;
                        state          <= ACCESS;
`ifdef DMEM_ARB_RR_EN
                        ptr            <= !pick1;
`endif
                    end else begin
                        mem_write <= 1'b0;
                        mem_read  <= 1'b0;
                    end
`ifndef DMEM_ARB_RR_EN
                    // req1 high and not picked implies port 0 won this arbitration
                    if (!req1 || pick1)
                        starve_cnt <= '0;
                    else if (starve_cnt != '1)
                        starve_cnt <= starve_cnt + 1'b1;
`endif
                end
                ACCESS: begin
                    if (mem_read) begin
                        if (sel) begin
                            rdata1  <= mem_read_data;
                            rvalid1 <= 1'b1;
                        end else begin
                            rdata0  <= mem_read_data;
                            rvalid0 <= 1'b1;
                        end
                    end
                    mem_write <= 1'b0;
                    mem_read  <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural single-port memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [11:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [11:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_write, mem_read;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:4095];
    logic        pre_we;
    logic [11:0] pre_addr;
    logic [31:0] pre_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(12), .DW(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_read_data(mem_read_data)
    );

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (mem_write)
            mem[mem_addr] <= mem_write_data;
    end
    assign mem_read_data = mem[mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},    {30'd0, gnt0, gnt1}, 32'd0);
        check({tag, "_rvalid"}, {30'd0, rvalid0, rvalid1}, 32'd0);
        check({tag, "_rdata0"}, rdata0, 32'd0);
        check({tag, "_rdata1"}, rdata1, 32'd0);
        check({tag, "_maddr"},  {20'd0, mem_addr}, 32'd0);
        check({tag, "_mwdata"}, mem_write_data, 32'd0);
        check({tag, "_mctl"},   {30'd0, mem_write, mem_read}, 32'd0);
    endtask

    logic exp_order [10];
    logic got_order [10];

    initial begin
`ifdef DMEM_ARB_RR_EN
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        pre_we = 1'b1; pre_addr = 12'd1; pre_data = 32'd200;
        tick();
        pre_addr = 12'd4095; pre_data = 32'h1234_5678;
        tick();
        pre_we = 1'b0;
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Port 0 read of word 1
        req0 = 1; we0 = 0; addr0 = 12'd1;
        tick();
        check("rd1_gnt", {30'd0, gnt0, gnt1}, 32'b10);
        check("rd1_mctl", {30'd0, mem_write, mem_read}, 32'b01);
        check("rd1_maddr", {20'd0, mem_addr}, 32'd1);
        req0 = 0;
        tick();
        check("rd1_rvalid", {30'd0, rvalid0, rvalid1}, 32'b10);
        check("rd1_rdata0", rdata0, 32'd200);
        check("rd1_gnt_off", {30'd0, gnt0, gnt1}, 32'b00);

        // Port 1 write then port 0 read of the same word
        req1 = 1; we1 = 1; addr1 = 12'd5; wdata1 = 32'hDEAD_BEEF;
        tick();
        check("wr_gnt1", {30'd0, gnt0, gnt1}, 32'b01);
        check("wr_mctl", {30'd0, mem_write, mem_read}, 32'b10);
        check("wr_mwdata", mem_write_data, 32'hDEAD_BEEF);
        req1 = 0; we1 = 0;
        req0 = 1; we0 = 0; addr0 = 12'd5;
        tick();
        check("wr_no_rvalid", {30'd0, rvalid0, rvalid1}, 32'b00);
        check("wr_gap_gnt", {30'd0, gnt0, gnt1}, 32'b00);
        check("rdata0_held", rdata0, 32'd200);
        tick();
        check("rbw_gnt0", {30'd0, gnt0, gnt1}, 32'b10);
        req0 = 0;
        tick();
        check("rbw_rvalid0", {30'd0, rvalid0, rvalid1}, 32'b10);
        check("rbw_rdata0", rdata0, 32'hDEAD_BEEF);

        // Continuous contention from a fresh reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0 = 1; we0 = 0; addr0 = 12'd1;
        req1 = 1; we1 = 0; addr1 = 12'd1;
        begin
            int ng;
            int last;
            ng = 0;
            last = -1;
            for (int c = 1; c <= 20; c++) begin
                tick();
                if (gnt0 && gnt1)
                    check("both_gnt", {30'd0, gnt0, gnt1}, 32'b00);
                if (gnt0 || gnt1) begin
                    if (last >= 0)
                        check("gnt_spacing", c - last, 32'd2);
                    if (ng < 10)
                        got_order[ng] = gnt1;
                    last = c;
                    ng++;
                end
            end
            check("num_grants", ng, 32'd10);
            for (int i = 0; i < 10; i++)
                check($sformatf("order%0d", i), {31'd0, got_order[i]}, {31'd0, exp_order[i]});
        end
        req0 = 0; req1 = 0;
        tick();
        tick();
        check("cont_rdata1", rdata1, 32'd200);

        // Reset arriving in the ACCESS cycle of a write
        req0 = 1; we0 = 1; addr0 = 12'd3; wdata0 = 32'd777;
        tick();
        check("rst_wr_gnt0", {30'd0, gnt0, gnt1}, 32'b10);
        check("rst_wr_mwrite", {31'd0, mem_write}, 32'd1);
        reset = 1'b1;
        req0 = 0; we0 = 0;
        tick();
        check_all_zero("post_rst");
        check("word3_model", mem[3], 32'd777);
        reset = 1'b0;
        tick();
        check("post_rst_rvalid", {30'd0, rvalid0, rvalid1}, 32'b00);
        req0 = 1; we0 = 0; addr0 = 12'd3;
        tick();
        req0 = 0;
        tick();
        check("word3_rvalid", {31'd0, rvalid0}, 32'd1);
        check("word3_rdata", rdata0, 32'd777);

        // Top word of the address space
        req0 = 1; we0 = 0; addr0 = 12'd4095;
        tick();
        check("top_maddr", {20'd0, mem_addr}, 32'd4095);
        check("top_rvalid_early", {31'd0, rvalid0}, 32'd0);
        req0 = 0;
        tick();
        check("top_rvalid", {31'd0, rvalid0}, 32'd1);
        check("top_rdata", rdata0, 32'h1234_5678);
        tick();
        check("top_rvalid_width", {31'd0, rvalid0}, 32'd0);
        check("top_rdata_held", rdata0, 32'h1234_5678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
